// File: rtl/auth_pkg.sv
// Shared definitions for the authentication initiator: message codes, result codes,
// FSM encoding, USB control request values and header field widths.
package auth_pkg;

  localparam int HDR_W   = 32;
  localparam int FIELD_W = 8;
  localparam int TMR_W   = 16;

  localparam logic [FIELD_W-1:0] AUTH_VER        = 8'h01;
  localparam logic [FIELD_W-1:0] REQ_BASE        = 8'h80;
  localparam logic [FIELD_W-1:0] REQ_GET_DIGESTS = 8'h81;
  localparam logic [FIELD_W-1:0] REQ_GET_CERT    = 8'h82;
  localparam logic [FIELD_W-1:0] REQ_CHALLENGE   = 8'h83;
  localparam logic [FIELD_W-1:0] RSP_DIGESTS     = 8'h01;
  localparam logic [FIELD_W-1:0] RSP_CERT        = 8'h02;
  localparam logic [FIELD_W-1:0] RSP_CHALLENGE   = 8'h03;
  localparam logic [FIELD_W-1:0] RSP_ERROR       = 8'h7F;

  localparam logic [7:0] AUTH_OUT = 8'd24;
  localparam logic [7:0] AUTH_IN  = 8'd25;
  localparam logic [7:0] BMRT_OUT = 8'h00;
  localparam logic [7:0] BMRT_IN  = 8'h80;

  typedef enum logic [1:0] {
    RT_INVALID   = 2'd0,
    RT_DIGESTS   = 2'd1,
    RT_CERT      = 2'd2,
    RT_CHALLENGE = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    RES_OK      = 2'd0,
    RES_ERR_RSP = 2'd1,
    RES_TIMEOUT = 2'd2,
    RES_BAD     = 2'd3
  } result_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUILD    = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_CHECK    = 3'd4,
    ST_ACK      = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  typedef struct packed {
    state_e           state;
    logic [HDR_W-1:0] rsp_hdr;
  } dbg_t;

  function automatic logic [FIELD_W-1:0] req_code(input logic [1:0] rt);
    case (rt)
      RT_DIGESTS:   req_code = REQ_GET_DIGESTS;
      RT_CERT:      req_code = REQ_GET_CERT;
      RT_CHALLENGE: req_code = REQ_CHALLENGE;
      default:      req_code = REQ_BASE;
    endcase
  endfunction

  // Request (AUTH_OUT) and response (AUTH_IN) transfer lengths per command.
  function automatic logic [15:0] out_wlength(input logic [1:0] rt);
    case (rt)
      RT_DIGESTS:   out_wlength = 16'd4;
      RT_CERT:      out_wlength = 16'd8;
      RT_CHALLENGE: out_wlength = 16'd36;
      default:      out_wlength = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] in_wlength(input logic [1:0] rt);
    case (rt)
      RT_DIGESTS:   in_wlength = 16'd260;
      RT_CERT:      in_wlength = 16'd516;
      RT_CHALLENGE: in_wlength = 16'd168;
      default:      in_wlength = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/auth_timeout_counter.sv
// Response timeout counter: load limit (also clears), clear, count enable,
// terminal-count output asserted while enabled at count == limit-1.
module auth_timeout_counter
  import auth_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  input  logic         i_enable,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic [W-1:0] r_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_limit <= i_limit;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = i_enable && (r_count == (r_limit - 1'b1));

endmodule

// File: rtl/auth_initiator.sv
// Initiator side of the Type-C authentication exchange: builds a request, waits for the
// responder, checks the response and reports a result. Optional retry: AUTH_INIT_RETRY_EN.
module auth_initiator
  import auth_pkg::*;
#(
  parameter int MSG_LEN   = 288,
  parameter int PAYLOAD_W = MSG_LEN - 32,
  parameter int DIGEST_TO = 1000,
  parameter int CERT_TO   = 4000,
  parameter int CHAL_TO   = 8000,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           req_type,
  input  logic [1:0]           slot,
  input  logic [7:0]           param2,
  input  logic [PAYLOAD_W-1:0] req_payload,
  output logic [MSG_LEN-1:0]   auth_msg_out,
  output logic                 init_req_out,
  input  logic                 resp_valid_in,
  input  logic [31:0]          resp_header_in,
  input  logic [PAYLOAD_W-1:0] resp_payload_in,
  output logic                 Ack_out,
  output logic [7:0]           bmRequestType,
  output logic [7:0]           bRequest,
  output logic [15:0]          wLength,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [7:0]           err_code,
  output logic [PAYLOAD_W-1:0] rsp_payload,
  output dbg_t                 dbg
);

  // Handshake: init_req_out is a one-cycle strobe per send attempt. resp_valid_in is
  // sampled only in WAIT_RSP; once taken, Ack_out stays high until resp_valid_in drops.

  localparam logic [TMR_W-1:0] DIGEST_LIM = TMR_W'(DIGEST_TO);
  localparam logic [TMR_W-1:0] CERT_LIM   = TMR_W'(CERT_TO);
  localparam logic [TMR_W-1:0] CHAL_LIM   = TMR_W'(CHAL_TO);

  state_e                 r_state;
  logic [1:0]             r_req_type;
  logic [MSG_LEN-1:0]     r_msg;
  logic [HDR_W-1:0]       r_rsp_hdr;
  logic [PAYLOAD_W-1:0]   r_rsp_payload;
  logic [1:0]             r_result;
  logic [7:0]             r_err_code;

  state_e                 w_next;
  logic                   w_tmr_load;
  logic                   w_tmr_clear;
  logic                   w_tmr_en;
  logic                   w_tc;
  logic                   w_can_retry;
  logic [TMR_W-1:0]       w_limit;

`ifdef AUTH_INIT_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0]     r_retry_cnt;

  assign w_can_retry = (r_retry_cnt < RETRY_W'(MAX_RETRY));
`else
  // MAX_RETRY is a non-negative count, so this folds to 0: first timeout is final.
  assign w_can_retry = (MAX_RETRY < 0);
`endif

  always_comb begin
    case (r_req_type)
      RT_DIGESTS: w_limit = DIGEST_LIM;
      RT_CERT:    w_limit = CERT_LIM;
      default:    w_limit = CHAL_LIM;
    endcase
  end

  assign w_tmr_load  = (r_state == ST_SEND);
  assign w_tmr_clear = (r_state == ST_IDLE);
  assign w_tmr_en    = (r_state == ST_WAIT_RSP);

  auth_timeout_counter #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_tmr_load),
    .i_clear  (w_tmr_clear),
    .i_limit  (w_limit),
    .i_enable (w_tmr_en),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (req_type != RT_INVALID) ? ST_BUILD : ST_DONE;
        end
      end
      ST_BUILD: w_next = ST_SEND;
      ST_SEND:  w_next = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        // A response in the terminal-count cycle takes priority over the timeout.
        if (resp_valid_in) begin
          w_next = ST_CHECK;
        end else if (w_tc) begin
          w_next = w_can_retry ? ST_SEND : ST_DONE;
        end
      end
      ST_CHECK: w_next = ST_ACK;
      ST_ACK: begin
        if (!resp_valid_in) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_type    <= '0;
      r_msg         <= '0;
      r_rsp_hdr     <= '0;
      r_rsp_payload <= '0;
      r_result      <= '0;
      r_err_code    <= '0;
`ifdef AUTH_INIT_RETRY_EN
      r_retry_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_req_type <= req_type;
            r_err_code <= '0;
`ifdef AUTH_INIT_RETRY_EN
            r_retry_cnt <= '0;
`endif
            if (req_type == RT_INVALID) begin
              r_result <= RES_BAD;
            end else begin
              r_result      <= RES_OK;
              r_rsp_payload <= '0;
            end
          end
        end
        ST_BUILD: begin
          r_msg <= {AUTH_VER, req_code(r_req_type), {6'b0, slot}, param2,
                    (r_req_type == RT_DIGESTS) ? {PAYLOAD_W{1'b0}} : req_payload};
        end
        ST_WAIT_RSP: begin
          if (resp_valid_in) begin
            r_rsp_hdr     <= resp_header_in;
            r_rsp_payload <= resp_payload_in;
          end else if (w_tc) begin
`ifdef AUTH_INIT_RETRY_EN
            if (w_can_retry) begin
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end else begin
              r_result <= RES_TIMEOUT;
            end
`else
            r_result <= RES_TIMEOUT;
`endif
          end
        end
        ST_CHECK: begin
          if (r_rsp_hdr[31:24] == AUTH_VER && r_rsp_hdr[23:16] == {6'b0, r_req_type}) begin
            r_result <= RES_OK;
          end else if (r_rsp_hdr[31:24] == AUTH_VER && r_rsp_hdr[23:16] == RSP_ERROR) begin
            r_result   <= RES_ERR_RSP;
            r_err_code <= r_rsp_hdr[15:8];
          end else begin
            r_result <= RES_BAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    init_req_out  = 1'b0;
    Ack_out       = 1'b0;
    bmRequestType = 8'h00;
    bRequest      = 8'h00;
    wLength       = 16'h0000;
    case (r_state)
      ST_SEND: begin
        init_req_out  = 1'b1;
        bmRequestType = BMRT_OUT;
        bRequest      = AUTH_OUT;
        wLength       = out_wlength(r_req_type);
      end
      ST_WAIT_RSP: begin
        bmRequestType = BMRT_IN;
        bRequest      = AUTH_IN;
        wLength       = in_wlength(r_req_type);
      end
      ST_ACK:  Ack_out = 1'b1;
      default: ;
    endcase
  end

  assign auth_msg_out  = r_msg;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign result        = r_result;
  assign err_code      = r_err_code;
  assign rsp_payload   = r_rsp_payload;
  assign dbg.state     = r_state;
  assign dbg.rsp_hdr   = r_rsp_hdr;

endmodule

// File: tb/tb_auth_initiator.sv
// Bench for auth_initiator: directed vector table, randomized transactions against a
// transaction-level model, and hand sequences for start-ignore and async reset.
module tb_auth_initiator;

  localparam int PW  = 256;
  localparam int ML  = 288;
  localparam int DTO = 16;
  localparam int CTO = 24;
  localparam int HTO = 32;
  localparam int MR  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    req_type = '0;
  logic [1:0]    slot = '0;
  logic [7:0]    param2 = '0;
  logic [PW-1:0] req_payload = '0;
  logic [ML-1:0] auth_msg_out;
  logic          init_req_out;
  logic          resp_valid_in = 1'b0;
  logic [31:0]   resp_header_in = '0;
  logic [PW-1:0] resp_payload_in = '0;
  logic          Ack_out;
  logic [7:0]    bmRequestType;
  logic [7:0]    bRequest;
  logic [15:0]   wLength;
  logic          busy;
  logic          done;
  logic [1:0]    result;
  logic [7:0]    err_code;
  logic [PW-1:0] rsp_payload;
  logic [34:0]   dbg;

  always #5 clk = ~clk;

  auth_initiator #(
    .MSG_LEN(ML), .PAYLOAD_W(PW), .DIGEST_TO(DTO), .CERT_TO(CTO), .CHAL_TO(HTO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .req_type(req_type), .slot(slot),
    .param2(param2), .req_payload(req_payload), .auth_msg_out(auth_msg_out),
    .init_req_out(init_req_out), .resp_valid_in(resp_valid_in),
    .resp_header_in(resp_header_in), .resp_payload_in(resp_payload_in),
    .Ack_out(Ack_out), .bmRequestType(bmRequestType), .bRequest(bRequest),
    .wLength(wLength), .busy(busy), .done(done), .result(result),
    .err_code(err_code), .rsp_payload(rsp_payload), .dbg(dbg)
  );

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [1:0]    rt;
    logic [1:0]    sl;
    logic [7:0]    p2;
    logic [PW-1:0] pl;
    int            dly;
    logic [31:0]   rh;
    logic [PW-1:0] rp;
    int            hold;
    bit            poke;
    logic [9:0]    exp_rr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd256();
    logic [PW-1:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[PW-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic int lim_of(input logic [1:0] rt);
    if (rt == 2'd1) return DTO;
    if (rt == 2'd2) return CTO;
    return HTO;
  endfunction

  // Outcome of one command as {result, err_code}; dly < 0 means no response at all.
  function automatic logic [9:0] model_rsp(input logic [1:0] rt, input int dly, input logic [31:0] rh);
    if (rt == 2'd0) return {2'd3, 8'd0};
    if (dly < 0) return {2'd2, 8'd0};
    if (rh[31:24] != 8'h01) return {2'd3, 8'd0};
    if (rh[23:16] == 8'(rt)) return {2'd0, 8'd0};
    if (rh[23:16] == 8'h7F) return {2'd1, rh[15:8]};
    return {2'd3, 8'd0};
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int lim, att, exp_done, exp_pulses, exp_acks, c, pulses, acks, done_c;
    logic [ML-1:0] exp_msg;
    logic [15:0] wl_out, wl_in;
    logic [9:0] got, exp;
    lim = lim_of(v.rt);
`ifdef AUTH_INIT_RETRY_EN
    att = MR + 1;
`else
    att = 1;
`endif
    exp_msg = {8'h01, 8'h80 | {6'b0, v.rt}, {6'b0, v.sl}, v.p2, (v.rt == 2'd1) ? {PW{1'b0}} : v.pl};
    wl_out = (v.rt == 2'd1) ? 16'd4 : (v.rt == 2'd2) ? 16'd8 : 16'd36;
    wl_in  = (v.rt == 2'd1) ? 16'd260 : (v.rt == 2'd2) ? 16'd516 : 16'd168;
    if (v.rt == 2'd0) begin
      exp_done = 1; exp_pulses = 0; exp_acks = 0;
    end else if (v.dly >= 0) begin
      exp_done = 5 + v.dly + v.hold; exp_pulses = 1; exp_acks = v.hold;
    end else begin
      exp_done = 2 + att * (lim + 1); exp_pulses = att; exp_acks = 0;
    end
    exp_q.push_back(v.exp_rr);

    start = 1'b1; req_type = v.rt; slot = v.sl; param2 = v.p2; req_payload = v.pl;
    pulses = 0; acks = 0; done_c = -1;
    for (c = 1; c <= 400 && done_c < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (v.poke && c == 4) start = 1'b1;
      if (v.poke && c == 5) start = 1'b0;
      if (init_req_out) begin
        pulses++;
        if (pulses == 1) chk_i({nm, "_send_latency"}, c, 2);
        chk({nm, "_msg"}, auth_msg_out, exp_msg);
        chk({nm, "_send_setup"}, {bmRequestType, bRequest, wLength}, {8'h00, 8'd24, wl_out});
      end
      if (v.rt != 2'd0 && c == 3)
        chk({nm, "_wait_setup"}, {bmRequestType, bRequest, wLength}, {8'h80, 8'd25, wl_in});
      if (Ack_out) begin
        acks++;
        if (acks == v.hold) resp_valid_in = 1'b0;
      end
      if (v.dly >= 0 && c == 3 + v.dly) begin
        resp_valid_in = 1'b1; resp_header_in = v.rh; resp_payload_in = v.rp;
      end
      if (done) done_c = c;
    end
    resp_valid_in = 1'b0;
    chk_i({nm, "_done_cycle"}, done_c, exp_done);
    chk_i({nm, "_req_pulses"}, pulses, exp_pulses);
    chk_i({nm, "_ack_cycles"}, acks, exp_acks);
    exp = exp_q.pop_front();
    got = {result, err_code};
    chk({nm, "_result_err"}, ML'(got), ML'(exp));
    if (v.rt != 2'd0 && v.dly >= 0) chk({nm, "_rsp_payload"}, ML'(rsp_payload), ML'(v.rp));
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, ML'({done, busy}), ML'(2'b00));
  endtask

  initial begin
    vec_t r;
    logic [PW-1:0] nonce;
    nonce = {32{8'hA5}};

    tbl[0] = '{2'd1, 2'd0, 8'h00, rnd256(), 10, 32'h01010000, rnd256(), 2, 1'b1, 10'h000};
    tbl[1] = '{2'd3, 2'd2, 8'h00, nonce, 5, 32'h01030000, rnd256(), 1, 1'b0, 10'h000};
    tbl[2] = '{2'd2, 2'd1, 8'h11, rnd256(), 3, 32'h017F0100, rnd256(), 1, 1'b0, {2'd1, 8'h01}};
    tbl[3] = '{2'd1, 2'd0, 8'h00, '0, -1, 32'h0, '0, 1, 1'b1, {2'd2, 8'h00}};
    tbl[4] = '{2'd1, 2'd0, 8'h00, '0, 2, 32'h02010000, rnd256(), 1, 1'b0, {2'd3, 8'h00}};
    tbl[5] = '{2'd0, 2'd1, 8'h22, rnd256(), -1, 32'h0, '0, 1, 1'b0, {2'd3, 8'h00}};
    tbl[6] = '{2'd1, 2'd3, 8'h44, '0, DTO - 1, 32'h01010000, rnd256(), 3, 1'b0, 10'h000};
    tbl[7] = '{2'd2, 2'd0, 8'h5A, rnd256(), 0, 32'h01010000, rnd256(), 1, 1'b0, {2'd3, 8'h00}};
    tbl[8] = '{2'd3, 2'd1, 8'h07, rnd256(), 7, 32'h017F2A00, rnd256(), 2, 1'b0, {2'd1, 8'h2A}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_msg", auth_msg_out, '0);
    chk("reset_ctl", ML'({init_req_out, Ack_out, bmRequestType, bRequest, wLength, busy, done, result, err_code}), '0);
    chk("reset_payload", ML'(rsp_payload), '0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomized transactions against the model
    for (int i = 0; i < 24; i++) begin
      r.rt = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      r.sl = 2'($urandom_range(0, 3));
      r.p2 = 8'($urandom_range(0, 255));
      r.pl = rnd256();
      r.dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, lim_of(r.rt) - 1));
      case ($urandom_range(0, 3))
        0: r.rh = {8'h01, 8'(r.rt), 16'($urandom())};
        1: r.rh = {8'h01, 8'h7F, 16'($urandom())};
        2: r.rh = {8'($urandom_range(2, 255)), 8'(r.rt), 16'($urandom())};
        default: r.rh = {8'h01, 8'($urandom_range(0, 255)), 16'($urandom())};
      endcase
      r.rp = rnd256();
      r.hold = int'($urandom_range(1, 3));
      r.poke = 1'b0;
      r.exp_rr = model_rsp(r.rt, r.dly, r.rh);
      run_txn(r, $sformatf("rnd%0d", i));
    end

    // Async reset in the middle of WAIT_RSP
    start = 1'b1; req_type = 2'd3; slot = 2'd2; param2 = 8'h00; req_payload = nonce;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_wait", ML'({busy, bmRequestType}), ML'({1'b1, 8'h80}));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_msg", auth_msg_out, '0);
    chk("arst_ctl", ML'({init_req_out, Ack_out, bmRequestType, bRequest, wLength, busy, done, result, err_code}), '0);
    chk("arst_payload", ML'(rsp_payload), '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", ML'({done, busy}), ML'(2'b00));
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", ML'({done, busy, init_req_out}), ML'(3'b000));
    end

    // Normal operation resumes after reset
    run_txn(tbl[0], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
